// File: rtl/char_writer.sv
// Writer side of the 80x25 character buffer: consumes a byte stream, tracks a cursor,
// writes printable codes and handles CR/LF/BS/FF, blanking rows as the cursor enters them.
module char_writer #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 25,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  buf_din,
  output logic [10:0] buf_addr,
  output logic        buf_wen,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col
);

  localparam int unsigned AW = 11;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 7;
  localparam logic [AW-1:0] SCREEN_LAST = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] ROW_SPAN    = AW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_e;

  state_e        state_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] clr_end_q;
  logic [7:0]    din_q;
  logic          wen_q;
  logic          ready_q;

  logic [RW-1:0] row_next_d;
  logic [AW-1:0] cur_addr_d;
  logic [AW-1:0] next_base_d;
  logic          printable_d;

  // Row after the cursor row (no scrolling) and the base addresses derived from it
  assign row_next_d  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
  assign cur_addr_d  = AW'(row_q) * AW'(COLS) + AW'(col_q);
  assign next_base_d = AW'(row_next_d) * AW'(COLS);
  assign printable_d = (in_data >= 8'h20) && (in_data <= 8'h7E);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      clr_end_q <= '0;
      din_q     <= 8'h00;
      wen_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (printable_d) begin
              state_q <= WRITE;
              wen_q   <= 1'b1;
              din_q   <= in_data;
              addr_q  <= cur_addr_d;
              ready_q <= 1'b0;
            end else begin
              case (in_data)
                8'h0D: col_q <= '0;
                8'h0A: begin
                  row_q     <= row_next_d;
                  state_q   <= CLEAR;
                  wen_q     <= 1'b1;
                  din_q     <= BLANK;
                  addr_q    <= next_base_d;
                  clr_end_q <= next_base_d + ROW_SPAN;
                  ready_q   <= 1'b0;
                end
                8'h08: begin
                  if (col_q != '0) col_q <= col_q - CW'(1);
                end
                8'h0C: begin
                  row_q     <= '0;
                  col_q     <= '0;
                  state_q   <= CLEAR;
                  wen_q     <= 1'b1;
                  din_q     <= BLANK;
                  addr_q    <= '0;
                  clr_end_q <= SCREEN_LAST;
                  ready_q   <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        WRITE: begin
          // Autowrap keeps the write enable up and rolls straight into the new row's clear
          if (col_q == CW'(COLS - 1)) begin
            col_q     <= '0;
            row_q     <= row_next_d;
            state_q   <= CLEAR;
            din_q     <= BLANK;
            addr_q    <= next_base_d;
            clr_end_q <= next_base_d + ROW_SPAN;
          end else begin
            col_q   <= col_q + CW'(1);
            state_q <= IDLE;
            wen_q   <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (addr_q == clr_end_q) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign buf_din    = din_q;
  assign buf_addr   = addr_q;
  assign buf_wen    = wen_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_char_writer.sv
// Bench for char_writer: vector table of bytes with expected cursor and busy time,
// plus hand sequences for timing, autowrap, LF row wrap and mid-clear reset.
module tb_char_writer;

  localparam int COLS = 80;
  localparam int ROWS = 25;

  logic        clk;
  logic        clr;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  buf_din;
  logic [10:0] buf_addr;
  logic        buf_wen;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  char_writer #(.COLS(80), .ROWS(25), .BLANK(8'h20)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .buf_din   (buf_din),
    .buf_addr  (buf_addr),
    .buf_wen   (buf_wen),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [18:0] exp_q[$];
  int mrow = 0;
  int mcol = 0;

  typedef struct {
    logic [7:0] b;
    int         row;
    int         col;
    int         low;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  function automatic void push_wr(input int a, input logic [7:0] d);
    exp_q.push_back({11'(a), d});
  endfunction

  function automatic void push_clear(input int first, input int n);
    for (int i = 0; i < n; i++) push_wr(first + i, 8'h20);
  endfunction

  // Reference model: cursor update and the writes each accepted byte must produce
  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(mrow * COLS + mcol, b);
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        push_clear(mrow * COLS, COLS);
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mrow = (mrow + 1) % ROWS;
      push_clear(mrow * COLS, COLS);
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (b == 8'h0C) begin
      mrow = 0;
      mcol = 0;
      push_clear(0, COLS * ROWS);
    end
  endfunction

  // Write monitor: every buffer write must match the head of the expected queue
  always @(negedge clk) begin
    if (!clr && buf_wen) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write",
                 buf_addr, buf_din);
      end else begin
        check("write_addr_data", int'({buf_addr, buf_din}), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    clr      = 1'b1;
    exp_q.delete();
    mrow = 0;
    mcol = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("send_ready_timeout", 0, 1);
    in_data  = b;
    in_valid = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    bit done = 1'b0;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else n++;
    end
    if (!done) check("ready_timeout", 0, 1);
  endtask

  task automatic check_cursor(input string nm, input int r, input int c);
    check({nm, "_row"}, int'(cursor_row), r);
    check({nm, "_col"}, int'(cursor_col), c);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int n1;
    int k;

    clr      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_buf_wen", int'(buf_wen), 0);
    check("rst_buf_din", int'(buf_din), 0);
    check("rst_buf_addr", int'(buf_addr), 0);
    check_cursor("rst", 0, 0);
    #2 clr = 1'b0;

    // Single printable byte: one write cycle, cursor moves one edge later
    send(8'h41);
    @(negedge clk);
    check("a_wen", int'(buf_wen), 1);
    check("a_addr", int'(buf_addr), 0);
    check("a_din", int'(buf_din), 8'h41);
    check("a_ready_low", int'(in_ready), 0);
    check("a_col_before", int'(cursor_col), 0);
    @(negedge clk);
    check("a_ready_back", int'(in_ready), 1);
    check("a_wen_off", int'(buf_wen), 0);
    check_cursor("a_after", 0, 1);

    // Vector table from reset
    do_reset();
    vecs[0]  = '{8'h41, 0, 1, 1};
    vecs[1]  = '{8'h42, 0, 2, 1};
    vecs[2]  = '{8'h08, 0, 1, 0};
    vecs[3]  = '{8'h08, 0, 0, 0};
    vecs[4]  = '{8'h08, 0, 0, 0};
    vecs[5]  = '{8'h0D, 0, 0, 0};
    vecs[6]  = '{8'h07, 0, 0, 0};
    vecs[7]  = '{8'hFF, 0, 0, 0};
    vecs[8]  = '{8'h0A, 1, 0, 80};
    vecs[9]  = '{8'h43, 1, 1, 1};
    vecs[10] = '{8'h7E, 1, 2, 1};
    vecs[11] = '{8'h1F, 1, 2, 0};
    vecs[12] = '{8'h0D, 1, 0, 0};
    vecs[13] = '{8'h20, 1, 1, 1};
    vecs[14] = '{8'h7F, 1, 1, 0};
    vecs[15] = '{8'h0C, 0, 0, 2000};
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].b);
      wait_ready(n);
      check($sformatf("vec%0d_busy", i), n, vecs[i].low);
      check_cursor($sformatf("vec%0d", i), vecs[i].row, vecs[i].col);
    end
    check("vec_drain", exp_q.size(), 0);

    // Full row of printables: autowrap then blanking of row 1
    do_reset();
    n1 = 0;
    for (int i = 0; i < COLS; i++) begin
      send(8'(33 + i));
      wait_ready(n);
      if (i < COLS - 1) begin
        if (n == 1) n1++;
      end else begin
        check("wrap_busy", n, COLS + 1);
      end
    end
    check("wrap_single_cycle_count", n1, COLS - 1);
    check_cursor("wrap", 1, 0);
    check("wrap_drain", exp_q.size(), 0);

    // LF from the last row wraps to row 0 and keeps the column
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'h41);
      wait_ready(n);
    end
    for (int i = 0; i < ROWS - 1; i++) begin
      send(8'h0A);
      wait_ready(n);
    end
    check_cursor("lf_pre", 24, 5);
    send(8'h0A);
    check_cursor("lf_edge", 0, 5);
    wait_ready(n);
    check("lf_busy", n, COLS);
    check("lf_drain", exp_q.size(), 0);

    // Reset in the middle of a screen clear
    do_reset();
    send(8'h0C);
    k = 0;
    while (!(buf_wen && buf_addr == 11'd1000) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("ff_reached_1000", int'(buf_addr), 1000);
    #2 clr = 1'b1;
    exp_q.delete();
    mrow = 0;
    mcol = 0;
    #1;
    check("abort_wen", int'(buf_wen), 0);
    check("abort_ready", int'(in_ready), 1);
    check("abort_din", int'(buf_din), 0);
    check("abort_addr", int'(buf_addr), 0);
    check_cursor("abort", 0, 0);
    @(negedge clk);
    #2 clr = 1'b0;
    send(8'h5A);
    wait_ready(n);
    check("post_abort_busy", n, 1);
    check_cursor("post_abort", 0, 1);
    check("post_abort_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/char_writer.md
# char_writer

Writer side of the character buffer: accepts a byte stream over a valid/ready handshake and updates the 80x25 character buffer that the video scan-out reads. The block tracks a cursor and writes printable characters at the cursor position. It interprets CR, LF, BS and FF, and blanks rows as the cursor enters them. Its outputs drive the buffer's data, address and write-enable inputs, which are currently tied off.

## Interface
- COLS, 80, characters per row
- ROWS, 25, rows per screen; COLS*ROWS must be at most 2048
- BLANK, 8'h20, fill code used for clears
- clk  in  1  pixel/system clock, the same clock as the buffer and scan-out
- clr  in  1  reset, asynchronous, active-high
- in_data  in  8  incoming character code
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a byte this cycle
- buf_din  out  8  buffer write data
- buf_addr  out  11  buffer write address, equal to row*COLS + col
- buf_wen  out  1  buffer write enable, one write per asserted cycle
- cursor_row  out  5  current cursor row, 0..ROWS-1
- cursor_col  out  7  current cursor column, 0..COLS-1

## Operation
- States: IDLE, WRITE, CLEAR.
- A byte is accepted on any rising edge where in_valid=1 and in_ready=1. in_ready=1 only in IDLE.
- Printable byte (0x20..0x7E) in IDLE: go to WRITE.
  - WRITE lasts exactly 1 cycle: buf_wen=1, buf_din=byte, buf_addr=cursor address.
  - At the end of WRITE, col increments.
  - If col was COLS-1, the cursor autowraps: col=0, row=(row+1) mod ROWS, then go to CLEAR of the new row. Otherwise return to IDLE.
- CR (0x0D): col=0 on the accepting edge. Stay in IDLE, no write.
- LF (0x0A): row=(row+1) mod ROWS, col unchanged, then CLEAR of the new row. There is no scrolling; row ROWS-1 wraps to row 0.
- BS (0x08): col=col-1, saturating at 0. Stay in IDLE, no write.
- FF (0x0C): row=0, col=0, then CLEAR of the whole screen.
- All other codes (0x00..0x1F except the four above, and 0x7F..0xFF) are consumed and ignored. State and cursor do not change.
- CLEAR (row): COLS consecutive cycles with buf_wen=1, buf_din=BLANK, buf_addr=row*COLS .. row*COLS+COLS-1 ascending. Then IDLE.
- CLEAR (screen): COLS*ROWS cycles, buf_addr 0 .. COLS*ROWS-1 ascending. Then IDLE.
- During CLEAR the cursor outputs already show the new position.
- buf_addr and buf_din are don't-care when buf_wen=0. They are held at their last value.

## Timing
- Reset values: in_ready=1, buf_wen=0, buf_din=8'h00, buf_addr=0, cursor_row=0, cursor_col=0, state IDLE.
- Assertion of clr aborts any WRITE or CLEAR immediately. buf_wen drops asynchronously. A partial clear is not resumed.
- All outputs are registered.
- Printable byte accepted at edge N:
  - buf_wen=1 during cycle N..N+1.
  - The cursor updates at edge N+1, and in_ready returns to 1 at edge N+1.
  - Sustained throughput is 1 printable byte per 2 cycles.
- CR, BS and ignored codes take effect at the accepting edge. in_ready stays 1, so back-to-back acceptance is allowed.
- LF accepted at edge N: cursor_row updates at edge N, and the COLS clear writes occupy cycles N..N+COLS. in_ready returns to 1 at edge N+COLS.
- Autowrap clear starts on the cycle after the WRITE cycle. in_ready returns to 1 COLS+1 cycles after the printable byte's write.
- While in_ready=0, in_valid and in_data are ignored and not latched. The source must hold the byte.
- buf_addr arithmetic is 11-bit unsigned and never exceeds COLS*ROWS-1.

## Test plan
- Reset then "A" (0x41) -> one cycle with buf_wen=1, buf_addr=0, buf_din=0x41; cursor (0,1); in_ready low for exactly 1 cycle.
- 80 printable bytes from (0,0) -> writes to addr 0..79; after the 80th, cursor (1,0), then 80 blank writes to addr 80..159, then in_ready=1.
- Cursor at (24,5), send LF -> cursor (0,5); blank writes to addr 0..79; in_ready low for 80 cycles.
- "AB", BS, BS, BS, CR -> writes at addr 0 and 1; cursor col goes 2→1→0→0→0; no extra writes.
- FF from any state of IDLE -> 2000 blank writes at addr 0..1999 ascending, cursor (0,0); 0x07 and 0xFF are consumed with no write and no cursor change.
- Assert clr mid screen-clear (at addr 1000) -> buf_wen=0 immediately; all outputs at reset values; next printable byte writes addr 0.
